// File: rtl/decode_stage.sv
// RV64I decode: drives RegisterFile read ports, bypasses same-cycle writeback and registers operands/immediate/control into ID/EX.
// Latency 1 cycle; holds ID/EX and drops in_ready while !out_ready, and inserts a single bubble on load-use.
module decode_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    output logic [REG_ADDR_W-1:0] RS1,
    output logic [REG_ADDR_W-1:0] RS2,
    input  logic [DATA_WIDTH-1:0] ReadData1,
    input  logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  wb_RegWrite,
    input  logic [REG_ADDR_W-1:0] wb_RD,
    input  logic [DATA_WIDTH-1:0] wb_WriteData,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            ex_opclass,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7b5,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [DATA_WIDTH-1:0] ex_rs1_val,
    output logic [DATA_WIDTH-1:0] ex_rs2_val,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [2:0] {
        OC_R   = 3'd0,
        OC_I   = 3'd1,
        OC_LD  = 3'd2,
        OC_ST  = 3'd3,
        OC_BR  = 3'd4,
        OC_ILL = 3'd7
    } opclass_e;

    typedef struct packed {
        opclass_e              opclass;
        logic                  reg_write;
        logic                  mem_read;
        logic                  rs2_used;
        logic [DATA_WIDTH-1:0] imm;
    } dec_t;

    dec_t                  dec;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic                  hazard;

    assign RS1 = instruction[19:15];
    assign RS2 = instruction[24:20];

    // RegisterFile only commits at the edge, so a same-cycle writeback must be forwarded here.
    always_comb begin
        rs1_val = ReadData1;
        rs2_val = ReadData2;
        if (RS1 == '0)
            rs1_val = '0;
        else if (wb_RegWrite && wb_RD == RS1)
            rs1_val = wb_WriteData;
        if (RS2 == '0)
            rs2_val = '0;
        else if (wb_RegWrite && wb_RD == RS2)
            rs2_val = wb_WriteData;
    end

    always_comb begin
        dec           = '0;
        dec.opclass   = OC_ILL;
        case (instruction[6:0])
            7'b0110011: begin
                dec.opclass   = OC_R;
                dec.reg_write = 1'b1;
                dec.rs2_used  = 1'b1;
            end
            7'b0010011: begin
                dec.opclass   = OC_I;
                dec.reg_write = 1'b1;
                dec.imm       = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]};
            end
            7'b0000011: begin
                dec.opclass   = OC_LD;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.imm       = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]};
            end
            7'b0100011: begin
                dec.opclass  = OC_ST;
                dec.rs2_used = 1'b1;
                dec.imm      = {{(DATA_WIDTH-12){instruction[31]}},
                                instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                dec.opclass  = OC_BR;
                dec.rs2_used = 1'b1;
                dec.imm      = {{(DATA_WIDTH-13){instruction[31]}}, instruction[31],
                                instruction[7], instruction[30:25], instruction[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Load in EX whose result the incoming instruction needs: hold it back one cycle.
    assign hazard = out_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == RS1) || ((ex_rd == RS2) && dec.rs2_used));

    assign in_ready = flush || ((!out_valid || out_ready) && !hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            ex_opclass   <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            stall_count  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid    <= 1'b1;
            ex_opclass   <= dec.opclass;
            ex_funct3    <= instruction[14:12];
            ex_funct7b5  <= instruction[30];
            ex_rd        <= dec.reg_write ? instruction[11:7] : '0;
            ex_reg_write <= dec.reg_write;
            ex_mem_read  <= dec.mem_read;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_imm       <= dec.imm;
        end else if (hazard && out_ready) begin
            out_valid <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
